// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the RV32I core (master) and the data-memory responder (slave).
//   i_data_addr        byte address
//   i_data_wr          right-justified write data
//   i_data_rd_en_ctrl  access size: 00 byte, 01 half, 10/11 word
//   i_data_rd_en_ma    read request
//   i_data_wr_en_ma    write request
//   o_data_ready       ready back to the core; low stalls the pipeline
//   o_data_rd          read data
//   o_data_err         sticky error flag
interface data_memory_responder_if;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wr;
    logic [1:0]  i_data_rd_en_ctrl;
    logic        i_data_rd_en_ma;
    logic        i_data_wr_en_ma;
    logic        o_data_ready;
    logic [31:0] o_data_rd;
    logic        o_data_err;

    modport master (
        output i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en_ma, i_data_wr_en_ma,
        input  o_data_ready, o_data_rd, o_data_err
    );

    modport slave (
        input  i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en_ma, i_data_wr_en_ma,
        output o_data_ready, o_data_rd, o_data_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory target for the RV32I core: word-organised RAM with byte-lane
// writes and a fixed number of wait states per access.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_memory_responder_if.slave (request in, ready/read data/error out)
// Optional feature: define DMEM_MISALIGN_TRAP_EN to suppress misaligned
// accesses and flag them on o_data_err; otherwise addresses are force-aligned.
// o_data_ready is combinational so the core stalls in the request cycle.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CW    = 4;
    localparam logic [63:0] BYTES = 64'(DEPTH_WORDS) * 64'd4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Access captured at the IDLE->BUSY edge
    typedef struct packed {
        logic [AW-1:0] idx;
        logic [1:0]    off;
        logic [1:0]    size;
        logic          is_wr;
        logic          kill;
        logic [31:0]   wdata;
    } req_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic [31:0]   rd_q, rd_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req_c;
    logic          oob_c;
    logic          misalign_c;
    logic [1:0]    off_c;
    logic          mem_we_c;
    logic [3:0]    be_c;
    logic [31:0]   wlane_c;
    logic [31:0]   rword_c;

    // Request decode: range check and alignment handling
    always_comb begin
        req_c = bus.i_data_rd_en_ma | bus.i_data_wr_en_ma;
        oob_c = 64'(bus.i_data_addr) >= BYTES;
`ifdef DMEM_MISALIGN_TRAP_EN
        off_c = bus.i_data_addr[1:0];
        case (bus.i_data_rd_en_ctrl)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = bus.i_data_addr[0];
            default: misalign_c = (bus.i_data_addr[1:0] != 2'b00);
        endcase
`else
        misalign_c = 1'b0;
        case (bus.i_data_rd_en_ctrl)
            2'b00:   off_c = bus.i_data_addr[1:0];
            2'b01:   off_c = {bus.i_data_addr[1], 1'b0};
            default: off_c = 2'b00;
        endcase
`endif
    end

    assign rword_c = mem[req_q.idx];

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    req_d.idx   = bus.i_data_addr[AW+1:2];
                    req_d.off   = off_c;
                    req_d.size  = bus.i_data_rd_en_ctrl;
                    req_d.is_wr = bus.i_data_wr_en_ma;
                    req_d.kill  = oob_c | misalign_c;
                    req_d.wdata = bus.i_data_wr;
                    cnt_d       = CW'(WAIT_STATES - 1);
                    err_d       = err_q | (bus.i_data_rd_en_ma & bus.i_data_wr_en_ma)
                                        | oob_c | misalign_c;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // Read data registered on entry to DONE, shifted down and zero-filled
                    if (!req_q.is_wr) begin
                        rd_d = req_q.kill ? 32'h0 : (rword_c >> {req_q.off, 3'b000});
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte-lane enables and lane-aligned write data
    always_comb begin
        case (req_q.size)
            2'b00:   be_c = 4'b0001 << req_q.off;
            2'b01:   be_c = 4'b0011 << req_q.off;
            default: be_c = 4'b1111;
        endcase
        wlane_c  = req_q.wdata << {req_q.off, 3'b000};
        mem_we_c = (state_q == DONE) && req_q.is_wr && !req_q.kill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; the write commits on the DONE->IDLE edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_c && be_c[i]) begin
                mem[req_q.idx][8*i +: 8] <= wlane_c[8*i +: 8];
            end
        end
    end

    assign bus.o_data_ready = ((state_q == IDLE) && !req_c) || (state_q == DONE);
    assign bus.o_data_rd    = rd_q;
    assign bus.o_data_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed steps followed by
// randomized accesses compared against a byte-array reference model.
module tb_data_memory_responder;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WS     = 2;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_memory_responder_if bus();

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [NBYTES];
    logic       merr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, sticky error, expected read value
    task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                         input bit rd, input bit wr, output logic [31:0] exp_rd);
        int unsigned n, a, base, off;
        bit mis, oob;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        oob = (addr >= 32'(NBYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr % n) != 0;
        a   = addr;
`else
        mis = 1'b0;
        a   = addr - (addr % n);
`endif
        if (rd && wr) merr = 1'b1;
        if (oob || mis) merr = 1'b1;
        exp_rd = 32'h0;
        if (wr) begin
            if (!oob && !mis)
                for (int k = 0; k < int'(n); k++) mm[a + 32'(k)] = wdata[8*k +: 8];
        end else if (!oob && !mis) begin
            off  = a % 4;
            base = a - off;
            for (int k = 0; k < 4 - int'(off); k++)
                exp_rd = exp_rd | (32'(mm[base + off + 32'(k)]) << (8 * k));
        end
    endtask

    // Drive one access starting just after a rising edge; returns read data and ready-low count
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                          input bit rd, input bit wr,
                          output logic [31:0] rdv, output logic errv, output int lat);
        bus.i_data_addr       = addr;
        bus.i_data_wr         = wdata;
        bus.i_data_rd_en_ctrl = size;
        bus.i_data_rd_en_ma   = rd;
        bus.i_data_wr_en_ma   = wr;
        lat  = 0;
        rdv  = 'x;
        errv = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_data_ready === 1'b1) begin
                rdv  = bus.o_data_rd;
                errv = bus.o_data_err;
                break;
            end
            lat++;
        end
        @(posedge clk);
        #1;
        bus.i_data_rd_en_ma = 1'b0;
        bus.i_data_wr_en_ma = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit rd, input bit wr, output logic [31:0] rdv);
        logic [31:0] exp_rd;
        logic        errv;
        int          lat;
        model(addr, wdata, size, rd, wr, exp_rd);
        access(addr, wdata, size, rd, wr, rdv, errv, lat);
        check($sformatf("%s.lat", tag), 32'(lat), 32'(WS + 1));
        check($sformatf("%s.err", tag), 32'(errv), 32'(merr));
        if (!wr) check($sformatf("%s.rd", tag), rdv, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdv;
        logic [31:0] a, d;
        int          kind;

        rst_n                 = 1'b0;
        merr                  = 1'b0;
        bus.i_data_addr       = '0;
        bus.i_data_wr         = '0;
        bus.i_data_rd_en_ctrl = 2'd0;
        bus.i_data_rd_en_ma   = 1'b0;
        bus.i_data_wr_en_ma   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", 32'(bus.o_data_ready), 32'd1);
        check("rst.rd",    bus.o_data_rd,         32'h0);
        check("rst.err",   32'(bus.o_data_err),   32'd0);
        @(posedge clk);
        #1;

        // Directed word/byte/half sequence
        do_op("w0",   32'h00, 32'h1111_2222, 2'd2, 1'b0, 1'b1, rdv);
        do_op("w10",  32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, rdv);
        do_op("r10",  32'h10, 32'h0,         2'd2, 1'b1, 1'b0, rdv);
        check("r10.const", rdv, 32'hDEAD_BEEF);
        do_op("wb13", 32'h13, 32'h0000_0055, 2'd0, 1'b0, 1'b1, rdv);
        do_op("r10b", 32'h10, 32'h0,         2'd2, 1'b1, 1'b0, rdv);
        check("r10b.const", rdv, 32'h55AD_BEEF);
        do_op("rh12", 32'h12, 32'h0,         2'd1, 1'b1, 1'b0, rdv);
        check("rh12.const", rdv, 32'h0000_55AD);
        do_op("w20",  32'h20, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b1, rdv);

        // Out-of-range write: dropped, error sticks
        do_op("woob", 32'(NBYTES), 32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1, rdv);
        do_op("r0",   32'h00, 32'h0, 2'd2, 1'b1, 1'b0, rdv);
        check("r0.const", rdv, 32'h1111_2222);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("oob.sticky", 32'(bus.o_data_err), 32'd1);
        @(posedge clk);
        #1;

        // Reset during BUSY of a write: write abandoned, error cleared
        bus.i_data_addr       = 32'h20;
        bus.i_data_wr         = 32'h1234_5678;
        bus.i_data_rd_en_ctrl = 2'd2;
        bus.i_data_wr_en_ma   = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        merr  = 1'b0;
        #1;
        bus.i_data_wr_en_ma = 1'b0;
        #1;
        check("rstbusy.ready", 32'(bus.o_data_ready), 32'd1);
        check("rstbusy.err",   32'(bus.o_data_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("r20", 32'h20, 32'h0, 2'd2, 1'b1, 1'b0, rdv);
        check("r20.const", rdv, 32'hCAFE_F00D);

        // Misaligned word read
        do_op("r22", 32'h22, 32'h0, 2'd2, 1'b1, 1'b0, rdv);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("r22.const", rdv, 32'h0);
        check("r22.errc",  32'(bus.o_data_err), 32'd1);
`else
        check("r22.const", rdv, 32'hCAFE_F00D);
        check("r22.errc",  32'(bus.o_data_err), 32'd0);
`endif

        // Randomized phase over a 64-byte window, with occasional out-of-range and dual requests
        for (int w = 0; w < 16; w++) begin
            do_op("init", 32'(w * 4), $urandom, 2'd2, 1'b0, 1'b1, rdv);
        end
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) a = 32'(NBYTES) + 32'($urandom_range(0, 255));
            else if ($urandom_range(0, 19) == 0) a = $urandom | 32'h8000_0000;
            else a = 32'($urandom_range(0, 63));
            d = $urandom;
            if (kind < 5)       do_op($sformatf("rnd%0d.r",  i), a, d, 2'($urandom_range(0, 3)), 1'b1, 1'b0, rdv);
            else if (kind < 9)  do_op($sformatf("rnd%0d.w",  i), a, d, 2'($urandom_range(0, 3)), 1'b0, 1'b1, rdv);
            else                do_op($sformatf("rnd%0d.rw", i), a, d, 2'($urandom_range(0, 3)), 1'b1, 1'b1, rdv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Data-memory target for the RV32I pipelined core: it answers the core's data-memory requests (address, write data, size control, read enable, write enable) and drives the data-ready and read-data signals back into it. It holds a word-organised synchronous RAM with byte-lane writes. It inserts a fixed number of wait states per access, so the core's hazard control stalls on `ready` low. It sits outside the core, beside the instruction memory, on the same clock.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 2: cycles spent in BUSY per access; legal range 1–15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_data_addr`  in  32  byte address from the core.
- `i_data_wr`  in  32  write data, right-justified.
- `i_data_rd_en_ctrl`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `i_data_rd_en_ma`  in  1  read request.
- `i_data_wr_en_ma`  in  1  write request.
- `o_data_ready`  out  1  ready to the core; low stalls the pipeline.
- `o_data_rd`  out  32  read data.
- `o_data_err`  out  1  sticky error flag.

## Operation
- FSM states:
  - IDLE:
    - A request (rd_en | wr_en) latches address, write data, size and direction, loads `cnt = WAIT_STATES-1`, and moves to BUSY.
    - With no request, it stays in IDLE.
  - BUSY: decrements `cnt`; at `cnt == 0` it moves to DONE.
  - DONE:
    - Lasts one cycle, then returns to IDLE.
    - A write commits to RAM on the DONE→IDLE edge.
    - Read data is valid during DONE.
- `o_data_ready` is combinational: `(IDLE & ~req) | DONE`. It drops in the same cycle a request appears.
- The core holds its request stable while `ready` is low. Inputs are sampled only at the IDLE→BUSY edge; later input changes are ignored.
- Simultaneous rd_en and wr_en: treated as a write; `o_data_err` is set.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Address ≥ `DEPTH_WORDS*4`:
  - Write is dropped.
  - Read returns 0.
  - `o_data_err` is set.
- Write lanes:
  - byte: lane `addr[1:0]`, data `i_data_wr[7:0]`.
  - half: lanes `{addr[1],0}` and `{addr[1],1}`, data `[15:0]`.
  - word: all four lanes.
- Read data is `word >> (8*addr[1:0])`, zero-filled from the top. The core performs sign/zero extension per funct3.
- `o_data_rd` holds its last value outside DONE. Reset value: 0.
- `o_data_err` is set as stated above and cleared only by reset. Reset value: 0.
- Reset (any time, including mid-access):
  - State returns to IDLE.
  - `cnt` is cleared.
  - Any pending write is abandoned.
  - RAM contents are not cleared.
  - `o_data_ready` = 1 once inputs are idle.

## Timing
- Access latency: request cycle (ready=0), then `WAIT_STATES` BUSY cycles, then one DONE cycle. Total `WAIT_STATES + 2` cycles from request assertion to the ready-high cycle.
- Default 2: the request is seen in cycle 0; ready=1 with data in cycle 3.
- Back-to-back requests: the request after DONE is recognised in the IDLE cycle that follows. There is at least one ready-low cycle per access.
- Read-after-write to the same address returns the new data, because the write commits before the next IDLE.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]=1`, or a word access with `addr[1:0]≠0`, is misaligned.
  - A misaligned write is suppressed; a misaligned read returns 0.
  - `o_data_err` is set.
  - Latency is unchanged.
- Not defined:
  - Half accesses force `addr[0]=0`; word accesses force `addr[1:0]=0`.
  - No error is raised for misalignment.

## Test plan
- Reset then idle: `o_data_ready`=1, `o_data_rd`=0, `o_data_err`=0.
- Word write 0xDEADBEEF to 0x10, then word read 0x10:
  - ready low for exactly 3 cycles per access.
  - DONE returns 0xDEADBEEF.
- Byte write 0x55 to 0x13 over the stored word, then word read 0x10 → 0x55ADBEEF. Half read 0x12 → 0x000055AD.
- Out-of-range write to `DEPTH_WORDS*4`:
  - RAM unchanged.
  - `o_data_err`=1 and stays set until `rst_n` is low.
- `rst_n` pulsed during BUSY of a word write 0x12345678 to 0x20:
  - FSM returns to IDLE.
  - A later read of 0x20 returns the old value.
- Word read at 0x22:
  - With `DMEM_MISALIGN_TRAP_EN`: returns 0, `err`=1.
  - Without it: returns word 0x20, `err`=0.
